// File: rtl/float_to_int.sv
// float_to_int: converts an IEEE-754 single-precision operand to a 32-bit
// two's-complement integer using a strobe/busy handshake on both sides.
// The mantissa is aligned one bit per cycle, so latency depends on the exponent.
// Optional feature macro: F2I_ROUND_NEAREST_EN
//   undefined -> truncate toward zero
//   defined   -> round to nearest, ties to even (guard/sticky tracked in SHIFT)
module float_to_int (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        f2i_input_STB,
  output logic        f2i_BUSY,
  output logic [31:0] output_z,
  output logic        f2i_output_STB,
  input  logic        output_module_BUSY
);

  localparam logic [2:0] GET_A   = 3'd0;
  localparam logic [2:0] UNPACK  = 3'd1;
  localparam logic [2:0] SPECIAL = 3'd2;
  localparam logic [2:0] SHIFT   = 3'd3;
  localparam logic [2:0] SIGN    = 3'd4;
  localparam logic [2:0] PUT_Z   = 3'd5;

  // Below this unbiased exponent the result is always zero. With rounding,
  // e = -1 (values in [0.5,1)) can still round up to 1.
`ifdef F2I_ROUND_NEAREST_EN
  localparam logic signed [9:0] ZERO_E = -10'sd1;
`else
  localparam logic signed [9:0] ZERO_E = 10'sd0;
`endif

  localparam logic [31:0] INT_INVALID = 32'h8000_0000;

  // Control state
  logic [2:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic              stb_q, stb_d;
  logic [31:0]       z_q, z_d;

  // Datapath state
  logic [31:0]       a_q, a_d;
  logic              s_q, s_d;
  logic signed [9:0] e_q, e_d;
  logic [31:0]       m_q, m_d;
  logic [31:0]       res_q, res_d;
`ifdef F2I_ROUND_NEAREST_EN
  logic              g_q, g_d;
  logic              st_q, st_d;
`endif

  // Two's-complement negate when the sign bit is set.
  function automatic logic [31:0] apply_sign(input logic s, input logic [31:0] m);
    return s ? (~m + 32'd1) : m;
  endfunction

`ifdef F2I_ROUND_NEAREST_EN
  // Round-to-nearest-even increment from guard, sticky and the kept LSB.
  function automatic logic [31:0] round_rne(input logic [31:0] m, input logic g,
                                            input logic st);
    return m + {31'd0, g & (st | m[0])};
  endfunction
`endif

  assign f2i_BUSY       = busy_q;
  assign f2i_output_STB = stb_q;
  assign output_z       = z_q;

  // Next-state and datapath update for the conversion FSM.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    stb_d   = stb_q;
    z_d     = z_q;
    a_d     = a_q;
    s_d     = s_q;
    e_d     = e_q;
    m_d     = m_q;
    res_d   = res_q;
`ifdef F2I_ROUND_NEAREST_EN
    g_d     = g_q;
    st_d    = st_q;
`endif
    case (state_q)
      GET_A: begin
        // Ready is raised one cycle after returning here and dropped on accept.
        busy_d = 1'b0;
        if (!busy_q && f2i_input_STB) begin
          a_d     = input_a;
          busy_d  = 1'b1;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        s_d = a_q[31];
        e_d = $signed({2'b00, a_q[30:23]}) - 10'sd127;
        m_d = {8'd0, 1'b1, a_q[22:0]};
`ifdef F2I_ROUND_NEAREST_EN
        g_d  = 1'b0;
        st_d = 1'b0;
`endif
        state_d = SPECIAL;
      end
      SPECIAL: begin
        // NaN/Inf and anything at or beyond 2^31 map to the invalid pattern;
        // -2^31 lands here too and happens to be representable as the same value.
        if (a_q[30:23] == 8'hFF || e_q >= 10'sd31) begin
          res_d   = INT_INVALID;
          state_d = PUT_Z;
        end else if (a_q[30:23] == 8'h00 || e_q < ZERO_E) begin
          res_d   = 32'd0;
          state_d = PUT_Z;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Walk the binary point until the exponent reaches 23 (integer aligned).
        if (e_q < 10'sd23) begin
          m_d = m_q >> 1;
          e_d = e_q + 10'sd1;
`ifdef F2I_ROUND_NEAREST_EN
          g_d  = m_q[0];
          st_d = st_q | g_q;
`endif
        end else if (e_q > 10'sd23) begin
          m_d = m_q << 1;
          e_d = e_q - 10'sd1;
        end else begin
          state_d = SIGN;
        end
      end
      SIGN: begin
`ifdef F2I_ROUND_NEAREST_EN
        res_d = apply_sign(s_q, round_rne(m_q, g_q, st_q));
`else
        res_d = apply_sign(s_q, m_q);
`endif
        state_d = PUT_Z;
      end
      PUT_Z: begin
        if (!stb_q) begin
          stb_d = 1'b1;
          z_d   = res_q;
        end else if (!output_module_BUSY) begin
          stb_d   = 1'b0;
          state_d = GET_A;
        end
      end
      default: begin
        state_d = GET_A;
      end
    endcase
  end

  // Control registers; reset wins over any same-edge handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      z_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
      z_q     <= z_d;
    end
  end

  // Datapath registers; contents are don't-care until written by the FSM.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    s_q   <= s_d;
    e_q   <= e_d;
    m_q   <= m_d;
    res_q <= res_d;
`ifdef F2I_ROUND_NEAREST_EN
    g_q   <= g_d;
    st_q  <= st_d;
`endif
  end

endmodule

// File: tb/tb_float_to_int.sv
// Testbench for float_to_int: directed corner values plus randomized operands,
// checked against an arithmetic reference model (value and latency).
// Honours F2I_ROUND_NEAREST_EN the same way as the design.
module tb_float_to_int;

  logic        clk;
  logic        rst;
  logic [31:0] input_a;
  logic        f2i_input_STB;
  logic        f2i_BUSY;
  logic [31:0] output_z;
  logic        f2i_output_STB;
  logic        output_module_BUSY;

  int npass;
  int ntot;

  float_to_int dut (
    .clk                (clk),
    .rst                (rst),
    .input_a            (input_a),
    .f2i_input_STB      (f2i_input_STB),
    .f2i_BUSY           (f2i_BUSY),
    .output_z           (output_z),
    .f2i_output_STB     (f2i_output_STB),
    .output_module_BUSY (output_module_BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: value = mant * 2^(e-23), converted with plain integer arithmetic.
  task automatic model(input logic [31:0] a, output logic [31:0] z, output int lat);
    int     ex;
    int     e;
    int     sh;
    longint mant;
    longint mag;
    longint rem;
    longint half;
    ex   = int'(a[30:23]);
    e    = ex - 127;
    mant = longint'({1'b1, a[22:0]});
`ifdef F2I_ROUND_NEAREST_EN
    if (ex == 255 || e >= 31) begin z = 32'h8000_0000; lat = 3; end
    else if (ex == 0 || e < -1) begin z = 32'd0; lat = 3; end
`else
    if (ex == 255 || e >= 31) begin z = 32'h8000_0000; lat = 3; end
    else if (ex == 0 || e < 0) begin z = 32'd0; lat = 3; end
`endif
    else begin
      if (e >= 23) begin
        mag = mant << (e - 23);
      end else begin
        sh   = 23 - e;
        mag  = mant >> sh;
        rem  = mant - (mag << sh);
        half = longint'(1) << (sh - 1);
`ifdef F2I_ROUND_NEAREST_EN
        if (rem > half || (rem == half && mag[0])) mag = mag + 1;
`else
        if (rem > half) mag = mag; // truncation discards the remainder
`endif
      end
      z   = a[31] ? 32'(-mag) : 32'(mag);
      lat = 5 + ((e > 23) ? (e - 23) : (23 - e));
    end
  endtask

  // One full transaction: wait ready, present operand, measure latency,
  // optionally hold backpressure, then release and watch the handshake unwind.
  task automatic do_conv(input logic [31:0] a, input int hold);
    logic [31:0] ez;
    int          elat;
    int          n;
    model(a, ez, elat);
    n = 0;
    while (f2i_BUSY && n < 200) begin @(posedge clk); #1; n++; end
    chk("ready", {31'd0, f2i_BUSY}, 32'd0);
    input_a       = a;
    f2i_input_STB = 1'b1;
    @(posedge clk); #1;
    f2i_input_STB = 1'b0;
    input_a       = $urandom;
    chk("busy_acc", {31'd0, f2i_BUSY}, 32'd1);
    n = 0;
    while (!f2i_output_STB && n < 100) begin
      @(posedge clk); #1; n++;
      input_a       = $urandom;
      f2i_input_STB = 1'($urandom_range(0, 1));
    end
    f2i_input_STB = 1'b0;
    chk($sformatf("lat_%h", a), 32'(n), 32'(elat));
    chk($sformatf("z_%h", a), output_z, ez);
    output_module_BUSY = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_stb", {31'd0, f2i_output_STB}, 32'd1);
      chk("bp_z", output_z, ez);
      chk("bp_busy", {31'd0, f2i_BUSY}, 32'd1);
    end
    output_module_BUSY = 1'b0;
    @(posedge clk); #1;
    chk("stb_fall", {31'd0, f2i_output_STB}, 32'd0);
    chk("busy_hold", {31'd0, f2i_BUSY}, 32'd1);
    chk("z_hold", output_z, ez);
    @(posedge clk); #1;
    chk("busy_fall", {31'd0, f2i_BUSY}, 32'd0);
  endtask

  logic [31:0] dir [12] = '{32'h4B00_0000, 32'hBF80_0000, 32'h3F00_0000, 32'h4060_0000,
                           32'h4020_0000, 32'h7FC0_0000, 32'h4F00_0000, 32'hFF80_0000,
                           32'hCF00_0000, 32'h4EFF_FFFF, 32'h0000_0001, 32'h3F40_0000};

  initial begin
    logic [31:0] a;
    int          seen;
    npass              = 0;
    ntot               = 0;
    rst                = 1'b1;
    input_a            = 32'd0;
    f2i_input_STB      = 1'b0;
    output_module_BUSY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, f2i_BUSY}, 32'd0);
    chk("rst_stb", {31'd0, f2i_output_STB}, 32'd0);
    chk("rst_z", output_z, 32'd0);
    rst = 1'b0;

    foreach (dir[i]) do_conv(dir[i], (i == 0) ? 10 : 0);

    // Reset mid-SHIFT on 1.0: nothing may be reported afterwards.
    input_a       = 32'h3F80_0000;
    f2i_input_STB = 1'b1;
    @(posedge clk); #1;
    f2i_input_STB = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_busy", {31'd0, f2i_BUSY}, 32'd0);
    chk("mrst_stb", {31'd0, f2i_output_STB}, 32'd0);
    chk("mrst_z", output_z, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (f2i_output_STB) seen++;
    end
    chk("mrst_stale", 32'(seen), 32'd0);
    do_conv(32'h3F80_0000, 0);

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      if (i % 4 != 0) a[30:23] = 8'($urandom_range(120, 160));
      do_conv(a, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/float_to_int.md
FLOAT_TO_INT -- requirements
Module: float_to_int

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high; clock clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 input_a  input  32  IEEE-754 single-precision operand, e.g. sum from the FP adder.
REQ-005 f2i_input_STB  input  1  input_a is valid.
REQ-006 f2i_BUSY  output  1  block cannot accept input.
REQ-007 output_z  output  32  two's-complement signed integer result.
REQ-008 f2i_output_STB  output  1  output_z is valid.
REQ-009 output_module_BUSY  input  1  downstream cannot accept.

Function
REQ-010 Input transaction SHALL occur on a rising edge where f2i_input_STB=1 and f2i_BUSY=0; input_a is latched and f2i_BUSY goes to 1 on that edge.
REQ-011 f2i_BUSY SHALL be 0 only in state GET_A; it SHALL be 1 from acceptance until the output transaction completes.
REQ-012 FSM states: GET_A -> UNPACK -> SPECIAL -> (SHIFT -> SIGN -> PUT_Z) or (PUT_Z); PUT_Z -> GET_A.
REQ-013 UNPACK: sign s=a[31]; unbiased exponent e=a[30:23]-127, 10-bit signed; m={1,a[22:0]} zero-extended to 32 bits (plus guard/sticky bits when rounding is enabled).
REQ-014 SPECIAL, NaN or Inf (a[30:23]=255): result 0x80000000, go to PUT_Z.
REQ-015 SPECIAL, e>=31, including -2^31 exactly: result 0x80000000, go to PUT_Z.
REQ-016 SPECIAL, zero/denormal (a[30:23]=0) or e below the zero threshold (REQ-028): result 0x00000000, go to PUT_Z.
REQ-017 SHIFT: one bit per cycle; e<23 -> m>>=1, e+=1; e>23 -> m<<=1, e-=1; e=23 -> go to SIGN; occupies |e-23|+1 cycles.
REQ-018 SIGN: apply rounding increment if enabled, then result = s ? -m : m, go to PUT_Z.
REQ-019 PUT_Z: f2i_output_STB<=1, output_z<=result; output transaction on an edge with f2i_output_STB=1 and output_module_BUSY=0; STB then <=0 and state <= GET_A.
REQ-020 Latency, acceptance edge to f2i_output_STB high: 5+|e-23| cycles on the shift path, 3 cycles on the special path.
REQ-021 output_z SHALL hold the last valid result while f2i_output_STB=0.
REQ-022 Input changes while f2i_BUSY=1 SHALL be ignored.
REQ-023 output_module_BUSY held high SHALL stall in PUT_Z indefinitely with STB=1 and output_z stable.

Reset
REQ-024 rst=1 on any edge, in any state, SHALL force GET_A, f2i_BUSY=0, f2i_output_STB=0, output_z=0x00000000.
REQ-025 rst has priority over all same-edge handshake events; an in-flight conversion SHALL be discarded and SHALL NOT be reported.

Configuration
REQ-026 Macro F2I_ROUND_NEAREST_EN SHALL select the rounding mode.
REQ-027 Undefined: truncate toward zero; bits shifted out are discarded.
REQ-028 Zero threshold for REQ-016: e<0 when F2I_ROUND_NEAREST_EN is undefined; e<-1 when it is defined.
REQ-029 Defined: SHIFT keeps guard (last bit shifted out) and sticky (OR of all earlier shifted-out bits); SIGN adds 1 when guard & (sticky | m[0]), i.e. round-to-nearest-even.
REQ-030 Defined: latency formula REQ-020 is unchanged.

Verification
REQ-031 0x4B000000 (8388608.0), STB pulse -> output_z=0x00800000, STB high 5 cycles after acceptance.
REQ-032 0xBF800000 (-1.0) -> 0xFFFFFFFF after 28 cycles; 0x3F000000 (0.5) -> 0 in 3 cycles undefined, 0 after 29 cycles defined (tie-to-even).
REQ-033 0x40600000 (3.5) -> 3 undefined, 4 defined; 0x40200000 (2.5) -> 2 in both builds.
REQ-034 0x7FC00000 (NaN), 0x4F000000 (2^31), 0xFF800000 (-Inf) -> 0x80000000 each, 3-cycle latency.
REQ-035 Backpressure: output_module_BUSY=1 for 10 cycles in PUT_Z -> STB and output_z stable, f2i_BUSY=1; release -> STB falls next edge, f2i_BUSY=0 one edge later.
REQ-036 rst pulse mid-SHIFT on 1.0 -> next edge f2i_BUSY=0, STB=0, output_z=0; no stale result; next input converts correctly.
